// File: rtl/riscv_i32_mem_responder_pkg.sv
// Shared types for the RISC-V memory responder: request/response bundles,
// the local sequencing state and the halfword-combine helper.
package riscv_i32_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_LO = 2'd1,
    ST_RD_HI = 2'd2,
    ST_RESP  = 2'd3
  } t_resp_state;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
  } t_riscv_mem_access_req;

  // 'wait' is a reserved word, so the stall flag is named mem_wait here.
  typedef struct packed {
    logic        mem_wait;
    logic [31:0] read_data;
  } t_riscv_mem_access_resp;

  function automatic logic [31:0] join_halves(input logic [15:0] hi_half,
                                              input logic [15:0] lo_half);
    return {hi_half, lo_half};
  endfunction

endpackage

// File: rtl/riscv_i32_mem_responder.sv
// Services core fetch/data requests from a one-cycle-latency SRAM, turning the
// latency into wait cycles and stitching halfword-aligned 32-bit reads.
module riscv_i32_mem_responder
  import riscv_i32_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           mem_access_req__address,
  input  logic [3:0]            mem_access_req__byte_enable,
  input  logic                  mem_access_req__write_enable,
  input  logic                  mem_access_req__read_enable,
  input  logic [31:0]           mem_access_req__write_data,
  output logic                  mem_access_resp__wait,
  output logic [31:0]           mem_access_resp__read_data,
  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic [3:0]            sram_write_enable,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [31:0]           sram_write_data,
  input  logic [31:0]           sram_read_data
);

  t_riscv_mem_access_req  w_req;
  t_riscv_mem_access_resp w_resp;

  t_resp_state            r_state;
  logic [ADDR_WIDTH+1:0]  r_addr;
  logic [31:0]            r_data;
  logic [15:0]            r_lo;

  logic [ADDR_WIDTH-1:0]  w_req_idx;
  logic [ADDR_WIDTH-1:0]  w_lo_idx;
  logic [ADDR_WIDTH-1:0]  w_hi_idx;
  logic                   w_wait;
  logic                   w_sel;
  logic                   w_rnw;
  logic [3:0]             w_we;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_unused_bits;

  assign w_req = '{
    address:      mem_access_req__address,
    byte_enable:  mem_access_req__byte_enable,
    write_enable: mem_access_req__write_enable,
    read_enable:  mem_access_req__read_enable,
    write_data:   mem_access_req__write_data
  };

  // Bits above the SRAM window and the byte offset never select anything.
  assign w_unused_bits = ^{w_req.address[31:ADDR_WIDTH+2], r_addr[0]};

  assign w_req_idx = w_req.address[ADDR_WIDTH+1:2];
  assign w_lo_idx  = r_addr[ADDR_WIDTH+1:2];
  assign w_hi_idx  = w_lo_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    w_wait = 1'b1;
    w_sel  = 1'b0;
    w_rnw  = 1'b1;
    w_we   = 4'b0000;
    w_addr = w_req_idx;
    if (reset_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req.write_enable) begin
            w_wait = 1'b0;
            w_sel  = 1'b1;
            w_rnw  = 1'b0;
            w_we   = w_req.byte_enable;
          end else if (w_req.read_enable) begin
            w_sel  = 1'b1;
          end else begin
            w_wait = 1'b0;
          end
        end
        ST_RD_LO: begin
          // Second word fetch only for a halfword-offset read still in progress.
          if (w_req.read_enable && r_addr[1]) begin
            w_sel  = 1'b1;
            w_addr = w_hi_idx;
          end
        end
        ST_RD_HI: begin
          w_wait = 1'b1;
        end
        ST_RESP: begin
          w_wait = 1'b0;
        end
        default: begin
          w_wait = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_req.write_enable && w_req.read_enable) begin
            r_addr  <= w_req.address[ADDR_WIDTH+1:0];
            r_state <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (!w_req.read_enable) begin
            r_state <= ST_IDLE;
          end else if (r_addr[1]) begin
            r_lo    <= sram_read_data[31:16];
            r_state <= ST_RD_HI;
          end else begin
            r_data  <= sram_read_data;
            r_state <= ST_RESP;
          end
        end
        ST_RD_HI: begin
          if (!w_req.read_enable) begin
            r_state <= ST_IDLE;
          end else begin
            r_data  <= join_halves(sram_read_data[15:0], r_lo);
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_resp.mem_wait  = w_wait;
  assign w_resp.read_data = (reset_n && (r_state == ST_RESP)) ? r_data : 32'h0;

  assign mem_access_resp__wait      = w_resp.mem_wait;
  assign mem_access_resp__read_data = w_resp.read_data;
  assign sram_select                = w_sel;
  assign sram_read_not_write        = w_rnw;
  assign sram_write_enable          = w_we;
  assign sram_address               = w_addr;
  assign sram_write_data            = w_req.write_data;

endmodule

// File: tb/tb_riscv_i32_mem_responder.sv
// Self-checking bench: SRAM model, byte-addressed reference memory and a
// per-cycle compare process driven by transaction-level expectations.
module tb_riscv_i32_mem_responder;

  localparam int AW     = 14;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [3:0]    req_be = '0;
  logic          req_we = 1'b0;
  logic          req_re = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          resp_wait;
  logic [31:0]   resp_rdata;
  logic          sram_select;
  logic          sram_rnw;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_address;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  always #5 clk = ~clk;

  riscv_i32_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .mem_access_req__address      (req_addr),
    .mem_access_req__byte_enable  (req_be),
    .mem_access_req__write_enable (req_we),
    .mem_access_req__read_enable  (req_re),
    .mem_access_req__write_data   (req_wdata),
    .mem_access_resp__wait        (resp_wait),
    .mem_access_resp__read_data   (resp_rdata),
    .sram_select                  (sram_select),
    .sram_read_not_write          (sram_rnw),
    .sram_write_enable            (sram_we),
    .sram_address                 (sram_address),
    .sram_write_data              (sram_wdata),
    .sram_read_data               (sram_rdata)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F0F;
  endfunction

  // SRAM model: one-cycle read latency, byte-lane writes.
  logic [31:0] sram_mem [NWORDS];
  logic        sram_init = 1'b1;
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < NWORDS; i++) sram_mem[i] <= seed_word(i);
    end else if (sram_select) begin
      if (sram_rnw) sram_rdata <= sram_mem[sram_address];
      else for (int l = 0; l < 4; l++)
        if (sram_we[l]) sram_mem[sram_address][8*l +: 8] <= sram_wdata[8*l +: 8];
    end
  end

  // Reference memory, seen as a byte array wrapping at the window size.
  logic [31:0] ref_mem [NWORDS];

  function automatic logic [7:0] ref_byte(input logic [AW+1:0] b);
    return ref_mem[b[AW+1:2]][8*b[1:0] +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [AW+1:0] b;
    b = a[AW+1:0];
    return {ref_byte((AW+2)'(b + 3)), ref_byte((AW+2)'(b + 2)),
            ref_byte((AW+2)'(b + 1)), ref_byte(b)};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    for (int l = 0; l < 4; l++)
      if (be[l]) ref_mem[a[AW+1:2]][8*l +: 8] = d[8*l +: 8];
  endtask

  // Per-cycle expectations, set by the stimulus tasks and checked at negedge.
  bit            chk_en = 1'b0;
  bit            e_wchk, e_wait, e_rdchk, e_sel, e_rnw;
  logic [31:0]   e_rd, e_wdata;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_we;
  int            n_checks = 0;
  int            n_errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_wait", 32'(resp_wait), 32'd1);
      chk("reset_read_data", resp_rdata, 32'd0);
      chk("reset_sram_select", 32'(sram_select), 32'd0);
      chk("reset_sram_we", 32'(sram_we), 32'd0);
    end else if (chk_en) begin
      if (e_wchk)  chk("wait", 32'(resp_wait), 32'(e_wait));
      if (e_rdchk) chk("read_data", resp_rdata, e_rd);
      chk("sram_select", 32'(sram_select), 32'(e_sel));
      if (e_sel) begin
        chk("sram_rnw", 32'(sram_rnw), 32'(e_rnw));
        chk("sram_address", 32'(sram_address), 32'(e_addr));
        if (!e_rnw) begin
          chk("sram_we", 32'(sram_we), 32'(e_we));
          chk("sram_wdata", sram_wdata, e_wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle();
    step();
    req_re = 1'b0; req_we = 1'b0;
    e_wchk = 1'b0; e_rdchk = 1'b0; e_sel = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input bit both);
    step();
    req_re = both; req_we = 1'b1; req_addr = a; req_be = be; req_wdata = d;
    e_wchk = 1'b1; e_wait = 1'b0;
    e_rdchk = both; e_rd = 32'h0;
    e_sel = 1'b1; e_rnw = 1'b0; e_addr = a[AW+1:2]; e_we = be; e_wdata = d;
    ref_write(a, be, d);
  endtask

  // Read held until completion; kdrop < 0 means never abandoned, otherwise
  // read_enable is dropped in cycle kdrop after the request.
  task automatic do_read_x(input logic [31:0] a, input bit use_lit,
                           input logic [31:0] lit, input int kdrop);
    int            lat;
    int            last;
    logic [31:0]   want;
    logic [AW-1:0] idx;
    lat  = a[1] ? 3 : 2;
    last = (kdrop < 0) ? lat : kdrop;
    want = use_lit ? lit : ref_read(a);
    idx  = a[AW+1:2];
    for (int k = 0; k <= last; k++) begin
      step();
      req_we = 1'b0; req_be = 4'($urandom); req_wdata = $urandom;
      if (k == kdrop) begin
        req_re = 1'b0;
        e_wchk = 1'b0; e_rdchk = 1'b0; e_sel = 1'b0;
      end else begin
        req_re = 1'b1;
        req_addr = (k == 0 || $urandom_range(0, 1) == 0) ? a : $urandom;
        e_wchk = 1'b1; e_wait = (k < lat);
        e_rdchk = (k == lat); e_rd = want;
        e_sel = (k == 0) || (k == 1 && lat == 3);
        e_rnw = 1'b1;
        e_addr = (k == 0) ? idx : AW'(idx + 1);
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit use_lit, input logic [31:0] lit);
    do_read_x(a, use_lit, lit, -1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0]   a;
    logic [AW-1:0] idx;
    case ($urandom_range(0, 3))
      0:       idx = AW'(NWORDS - 1);
      1:       idx = AW'($urandom_range(0, 7));
      default: idx = AW'($urandom_range(0, 63));
    endcase
    a = $urandom;
    a[AW+1:2] = idx;
    if ($urandom_range(0, 3) != 0) a[31:AW+2] = '0;
    return a;
  endfunction

  initial begin
    int          kind;
    logic [31:0] a;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = seed_word(i);
    e_wchk = 1'b0; e_rdchk = 1'b0; e_sel = 1'b0; e_rnw = 1'b1;
    e_rd = '0; e_wdata = '0; e_addr = '0; e_we = '0;
    repeat (3) @(posedge clk);
    #1;
    sram_init = 1'b0;
    reset_n   = 1'b1;
    chk_en    = 1'b1;

    // Aligned read
    do_write(32'h40, 4'hF, 32'h11223344, 1'b0);
    do_read(32'h40, 1'b1, 32'h11223344);
    // Unaligned read
    do_write(32'h40, 4'hF, 32'hAAAA1111, 1'b0);
    do_write(32'h44, 4'hF, 32'h2222BBBB, 1'b0);
    do_read(32'h42, 1'b1, 32'hBBBBAAAA);
    // Byte-lane write
    do_write(32'h40, 4'hF, 32'h0, 1'b0);
    do_write(32'h40, 4'b0101, 32'hDEADBEEF, 1'b0);
    do_read(32'h40, 1'b1, 32'h00AD00EF);
    // Wrap of the word index
    do_write(32'hFFFC, 4'hF, 32'h5555ABCD, 1'b0);
    do_write(32'h0, 4'hF, 32'h12346666, 1'b0);
    do_read(32'hFFFE, 1'b1, 32'h66665555);
    // Both enables behave as a write with zero read data
    do_write(32'h48, 4'hF, 32'h0BADF00D, 1'b1);
    do_read(32'h48, 1'b1, 32'h0BADF00D);
    // Abandon in RD_HI then in RD_LO, each followed by an immediate write
    do_read_x(32'h42, 1'b0, 32'h0, 2);
    do_write(32'h50, 4'hF, 32'h13572468, 1'b0);
    do_read_x(32'h42, 1'b0, 32'h0, 1);
    do_write(32'h54, 4'hF, 32'h24681357, 1'b0);
    do_read(32'h42, 1'b0, 32'h0);
    // Reset during RD_LO
    do_write(32'h80, 4'hF, 32'hCAFEF00D, 1'b0);
    do_write(32'h84, 4'hF, 32'h89ABCDEF, 1'b0);
    step();
    req_re = 1'b1; req_we = 1'b0; req_addr = 32'h82;
    e_wchk = 1'b1; e_wait = 1'b1; e_rdchk = 1'b0;
    e_sel = 1'b1; e_rnw = 1'b1; e_addr = AW'(32'h20);
    step();
    reset_n = 1'b0;
    do_write(32'h100, 4'hF, 32'h0F0F0F0F, 1'b0);
    do_read(32'h80, 1'b1, 32'hCAFEF00D);
    do_read(32'h82, 1'b1, 32'hCDEFCAFE);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 99);
      a = rand_addr();
      if (kind < 35) begin
        do_write(a, 4'($urandom), $urandom, 1'b0);
      end else if (kind < 40) begin
        do_write(a, 4'($urandom), $urandom, 1'b1);
      end else if (kind < 85) begin
        a[0] = 1'b0;
        do_read(a, 1'b0, 32'h0);
      end else if (kind < 93) begin
        a[0] = 1'b0;
        do_read_x(a, 1'b0, 32'h0, $urandom_range(1, a[1] ? 3 : 2));
        do_write(rand_addr(), 4'($urandom), $urandom, 1'b0);
      end else begin
        idle();
      end
    end

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
